// File: rtl/alu_logic_capture_if.sv
// Handshake bundle between the XOR/XNOR logic units, the capture stage and its consumer.
interface alu_logic_capture_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [WIDTH-1:0] xor_in;
   logic [WIDTH-1:0] xnor_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_parity;

   modport master (
      output in_valid, in_sel, xor_in, xnor_in, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_parity
   );

   modport slave (
      input  in_valid, in_sel, xor_in, xnor_in, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_parity
   );
endinterface

// File: rtl/alu_logic_capture.sv
// Selects a logic-unit result, updates a running accumulator and queues tagged results in a FIFO.
// Define ALU_LOGIC_CAPTURE_PARITY_EN to store and present a per-entry parity bit.
module alu_logic_capture #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_logic_capture_if.slave     bus,
   output logic [WIDTH-1:0]       acc,
   output logic [7:0]             txn_count
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic             mem_zero [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr, head_ptr_nxt;
   logic [CW-1:0]    count;
   logic             full, empty, push, pop;
   logic             load_head, head_from_in;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] out_data_r;
   logic             out_zero_r;

   assign full          = (count == CW'(DEPTH));
   assign empty         = (count == '0);
   assign push          = bus.in_valid && !full;
   assign pop           = !empty && bus.out_ready;
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_data  = out_data_r;
   assign bus.out_zero  = out_zero_r;

   always_comb begin
      result = '0;
      unique case (bus.in_sel)
         2'b00:   result = bus.xor_in;
         2'b01:   result = bus.xnor_in;
         2'b10:   result = acc ^ bus.xor_in;
         default: result = '0;
      endcase
   end

   // Output registers reload whenever the head entry changes; otherwise they hold.
   always_comb begin
      head_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
      load_head    = (push && empty) || (pop && ((count > CW'(1)) || push));
      head_from_in = push && (empty || (count == CW'(1)));
   end

`ifdef ALU_LOGIC_CAPTURE_PARITY_EN
   logic mem_par [DEPTH];
   logic out_parity_r;

   assign bus.out_parity = out_parity_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity_r <= 1'b0;
      end else begin
         if (push) mem_par[wr_ptr] <= ^result;
         if (load_head) out_parity_r <= head_from_in ? ^result : mem_par[head_ptr_nxt];
      end
   end
`else
   assign bus.out_parity = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         txn_count  <= '0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         out_data_r <= '0;
         out_zero_r <= 1'b0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= result;
            mem_zero[wr_ptr] <= (result == '0);
            wr_ptr           <= wr_ptr + PW'(1);
            acc              <= result;
            txn_count        <= txn_count + 8'd1;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (load_head) begin
            out_data_r <= head_from_in ? result : mem_data[head_ptr_nxt];
            out_zero_r <= head_from_in ? (result == '0) : mem_zero[head_ptr_nxt];
         end
      end
   end
endmodule

// File: tb/tb_alu_logic_capture.sv
// Directed bench for alu_logic_capture: queue-based reference model checked every cycle.
module tb_alu_logic_capture;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] acc;
   logic [7:0]       txn_count;

   alu_logic_capture_if #(.WIDTH(WIDTH)) bus ();

   alu_logic_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .acc       (acc),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             z;
      logic             p;
   } ent_t;

   ent_t             q[$];
   logic [WIDTH-1:0] m_acc;
   int               m_txn;
   ent_t             m_show;
   int               n_pop;
   bit               check_en = 0;
   int               n_tests = 0;
   int               n_fail = 0;

   function automatic logic exp_par(input logic [WIDTH-1:0] v);
`ifdef ALU_LOGIC_CAPTURE_PARITY_EN
      return ^v;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: transaction-level view of the stage.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_acc  = '0;
         m_txn  = 0;
         m_show = '{d: '0, z: 1'b0, p: 1'b0};
         n_pop  = 0;
      end else begin
         logic             do_pop, do_push;
         logic [WIDTH-1:0] r;
         do_pop  = (q.size() > 0) && bus.out_ready;
         do_push = bus.in_valid && (q.size() < DEPTH);
         case (bus.in_sel)
            2'b00:   r = bus.xor_in;
            2'b01:   r = bus.xnor_in;
            2'b10:   r = m_acc ^ bus.xor_in;
            default: r = '0;
         endcase
         if (do_pop) begin
            void'(q.pop_front());
            n_pop++;
         end
         if (do_push) begin
            q.push_back('{d: r, z: (r == 0), p: exp_par(r)});
            m_acc = r;
            m_txn = (m_txn + 1) % 256;
         end
         if (q.size() > 0) m_show = q[0];
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         chk("out_data", 32'(bus.out_data), 32'(m_show.d));
         chk("out_zero", 32'(bus.out_zero), 32'(m_show.z));
         chk("out_parity", 32'(bus.out_parity), 32'(m_show.p));
         chk("acc", 32'(acc), 32'(m_acc));
         chk("txn_count", 32'(txn_count), 32'(m_txn));
      end
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'b00;
      bus.xor_in    = '0;
      bus.xnor_in   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_en = 1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);

      // First transaction, visible one cycle after accept.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'b00;
      bus.xor_in    = 16'hF0F0;
      @(negedge clk);
      bus.in_sel    = 2'b01;
      bus.xnor_in   = 16'h0000;
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_data", 32'(bus.out_data), 32'hF0F0);
      chk("t1_zero", 32'(bus.out_zero), 32'd0);
      chk("t1_parity", 32'(bus.out_parity), 32'd0);
      chk("t1_acc", 32'(acc), 32'hF0F0);
      chk("t1_txn", 32'(txn_count), 32'd1);
      @(negedge clk);
      chk("xnor_data", 32'(bus.out_data), 32'h0000);
      chk("xnor_zero", 32'(bus.out_zero), 32'd1);

      // Accumulate chain.
      bus.in_sel = 2'b11;
      @(negedge clk);
      chk("clr_acc", 32'(acc), 32'h0000);
      bus.in_sel = 2'b10;
      bus.xor_in = 16'h00FF;
      @(negedge clk);
      chk("acc1", 32'(acc), 32'h00FF);
      chk("acc1_data", 32'(bus.out_data), 32'h00FF);
      bus.xor_in = 16'h0F0F;
      @(negedge clk);
      chk("acc2", 32'(acc), 32'h0FF0);
      chk("acc2_data", 32'(bus.out_data), 32'h0FF0);
      chk("acc2_parity", 32'(bus.out_parity), 32'd0);
      chk("acc2_txn", 32'(txn_count), 32'd5);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd0);
      chk("hold_data", 32'(bus.out_data), 32'h0FF0);

      // Stall: two accepted, third refused.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'b00;
      bus.xor_in    = 16'h1234;
      @(negedge clk);
      bus.xor_in = 16'h5678;
      @(negedge clk);
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      bus.xor_in = 16'h9ABC;
      @(negedge clk);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_acc", 32'(acc), 32'h5678);
      chk("stall_txn", 32'(txn_count), 32'd7);
      chk("stall_head", 32'(bus.out_data), 32'h1234);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_head2", 32'(bus.out_data), 32'h5678);
      chk("drain_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("drain_empty", 32'(bus.out_valid), 32'd0);

      // Streaming from a fresh reset: 300 accepts, counter wraps.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'b00;
      for (int i = 0; i < 300; i++) begin
         bus.xor_in = 16'(i + 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("stream_txn", 32'(txn_count), 32'd44);
      chk("stream_pops", 32'(n_pop), 32'd299);
      chk("stream_acc", 32'(acc), 32'h012C);
      @(negedge clk);

      // Reset while full with a nonzero accumulator.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.xor_in    = 16'h00A5;
      @(negedge clk);
      bus.xor_in = 16'h5A00;
      @(negedge clk);
      chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
      chk("pre_rst_acc", 32'(acc), 32'h5A00);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_valid", 32'(bus.out_valid), 32'd0);
      chk("rst2_acc", 32'(acc), 32'd0);
      chk("rst2_txn", 32'(txn_count), 32'd0);
      chk("rst2_ready", 32'(bus.in_ready), 32'd1);

      // Odd-weight result.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.xor_in    = 16'h0001;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("par_data", 32'(bus.out_data), 32'h0001);
`ifdef ALU_LOGIC_CAPTURE_PARITY_EN
      chk("par_bit", 32'(bus.out_parity), 32'd1);
`else
      chk("par_tied", 32'(bus.out_parity), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
